fetch_sequencer: RTL and testbench

Instruction fetch/sequencing controller that drives the program counter's command interface (IncPC, LoadPC, SelPC, A, B). It reads the 12-bit instruction word returned for the current PC address, decodes flow-control opcodes, services one level of interrupt, and issues exactly one PC command per instruction. It sits between instruction memory and the PC block, closing the fetch loop.

---
 rtl/fetch_sequencer_if.sv | 28 ++
 rtl/fetch_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Bundle of the fetch loop signals between instruction memory / PC block
// and the fetch sequencer. The master side is the sequencer itself.
interface fetch_sequencer_if;
    logic [11:0] IM_data;
    logic [7:0]  PC_in;
    logic        Z;
    logic        IRQ;
    logic        Stall;
    logic        IncPC;
    logic        LoadPC;
    logic        SelPC;
    logic [7:0]  A;
    logic [3:0]  B;
    logic [11:0] IR;
    logic        IRQ_ack;
    logic        Halted;
    logic        Illegal;

    modport master (
        input  IM_data, PC_in, Z, IRQ, Stall,
        output IncPC, LoadPC, SelPC, A, B, IR, IRQ_ack, Halted, Illegal
    );

    modport slave (
        output IM_data, PC_in, Z, IRQ, Stall,
        input  IncPC, LoadPC, SelPC, A, B, IR, IRQ_ack, Halted, Illegal
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing controller. Waits out the memory latency,
// latches and decodes one instruction (or takes an interrupt), then holds a
// single PC command for two cycles so the half-rate PC block sees it once.
module fetch_sequencer #(
    parameter int unsigned MEM_LAT = 1,     // 1..4 cycles
    parameter logic [3:0]  VEC     = 4'hF
) (
    input  logic              CLK,
    input  logic              CLB,
    fetch_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_LATCH,
        S_EXEC1,
        S_EXEC2,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_JZ   = 4'h2;
    localparam logic [3:0] OP_HALT = 4'h3;
    localparam logic [3:0] OP_RST  = 4'h5;
    localparam logic [3:0] OP_RTI  = 4'h6;
    localparam logic [3:0] OP_CLR  = 4'hF;

    // Last wait-counter value before leaving FETCH.
    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        inc_q, inc_d;
    logic        load_q, load_d;
    logic        sel_q, sel_d;
    logic [7:0]  a_q, a_d;
    logic [3:0]  b_q, b_d;
    logic [11:0] ir_q, ir_d;
    logic        ack_q, ack_d;
    logic        ill_q, ill_d;
    logic        halt_pend_q, halt_pend_d;
    logic        in_service_q, in_service_d;
    logic [7:0]  ret_q, ret_d;

    logic [3:0]  opcode;
    logic [7:0]  operand;
    logic        exec;

    assign opcode  = bus.IM_data[11:8];
    assign operand = bus.IM_data[7:0];
    assign exec    = (state_q == S_EXEC1) || (state_q == S_EXEC2);

    // Next-state and command decode; every register defaults to holding.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        inc_d        = inc_q;
        load_d       = load_q;
        sel_d        = sel_q;
        a_d          = a_q;
        b_d          = b_q;
        ir_d         = ir_q;
        ack_d        = 1'b0;
        ill_d        = 1'b0;
        halt_pend_d  = halt_pend_q;
        in_service_d = in_service_q;
        ret_d        = ret_q;

        case (state_q)
            S_RESET: begin
                cnt_d   = 2'd0;
                state_d = S_FETCH;
            end

            S_FETCH: begin
                // Stalled cycles do not count toward the memory latency.
                if (!bus.Stall) begin
                    if (cnt_q == LAT_LAST) begin
                        cnt_d   = 2'd0;
                        state_d = S_LATCH;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end

            S_LATCH: begin
                state_d     = S_EXEC1;
                inc_d       = 1'b0;
                load_d      = 1'b0;
                halt_pend_d = 1'b0;
                if (bus.IRQ && !in_service_q) begin
                    // Interrupt beats whatever was fetched; that word is
                    // refetched after RTI because PC is saved unchanged.
                    ret_d        = bus.PC_in;
                    in_service_d = 1'b1;
                    ack_d        = 1'b1;
                    load_d       = 1'b1;
                    sel_d        = 1'b1;
                    b_d          = VEC;
                end else begin
                    ir_d = bus.IM_data;
                    case (opcode)
                        OP_NOP: inc_d = 1'b1;
                        OP_JMP: begin
                            load_d = 1'b1;
                            sel_d  = 1'b0;
                            a_d    = operand;
                        end
                        OP_JZ: begin
                            if (bus.Z) begin
                                load_d = 1'b1;
                                sel_d  = 1'b0;
                                a_d    = operand;
                            end else begin
                                inc_d = 1'b1;
                            end
                        end
                        OP_HALT: halt_pend_d = 1'b1;
                        OP_RST: begin
                            load_d = 1'b1;
                            sel_d  = 1'b1;
                            b_d    = operand[3:0];
                        end
                        OP_RTI: begin
                            if (in_service_q) begin
                                load_d       = 1'b1;
                                sel_d        = 1'b0;
                                a_d          = ret_q;
                                in_service_d = 1'b0;
                            end else begin
                                inc_d = 1'b1;
                            end
                        end
                        OP_CLR: begin
                            // Simultaneous inc+load makes the PC clear to 0.
                            inc_d  = 1'b1;
                            load_d = 1'b1;
                        end
                        default: begin
                            inc_d = 1'b1;
                            ill_d = 1'b1;
                        end
                    endcase
                end
            end

            S_EXEC1: state_d = S_EXEC2;

            S_EXEC2: state_d = halt_pend_q ? S_HALT : S_FETCH;

            S_HALT: state_d = S_HALT;

            default: state_d = S_RESET;
        endcase
    end

    // State and datapath registers, cleared immediately by CLB.
    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) begin
            state_q      <= S_RESET;
            cnt_q        <= 2'd0;
            inc_q        <= 1'b0;
            load_q       <= 1'b0;
            sel_q        <= 1'b0;
            a_q          <= 8'h00;
            b_q          <= 4'h0;
            ir_q         <= 12'h000;
            ack_q        <= 1'b0;
            ill_q        <= 1'b0;
            halt_pend_q  <= 1'b0;
            in_service_q <= 1'b0;
            ret_q        <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            inc_q        <= inc_d;
            load_q       <= load_d;
            sel_q        <= sel_d;
            a_q          <= a_d;
            b_q          <= b_d;
            ir_q         <= ir_d;
            ack_q        <= ack_d;
            ill_q        <= ill_d;
            halt_pend_q  <= halt_pend_d;
            in_service_q <= in_service_d;
            ret_q        <= ret_d;
        end
    end

    // Commands are only asserted during the two-cycle execute window.
    assign bus.IncPC   = exec & inc_q;
    assign bus.LoadPC  = exec & load_q;
    assign bus.SelPC   = sel_q;
    assign bus.A       = a_q;
    assign bus.B       = b_q;
    assign bus.IR      = ir_q;
    assign bus.IRQ_ack = ack_q;
    assign bus.Illegal = ill_q;
    assign bus.Halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected commands are queued when an
// instruction is presented and compared when the sequencer reaches EXEC1.
module tb_fetch_sequencer;

    logic CLK;
    logic CLB;
    int   checks;
    int   failures;

    fetch_sequencer_if bus ();

    fetch_sequencer #(.MEM_LAT(1), .VEC(4'hF)) dut (
        .CLK (CLK),
        .CLB (CLB),
        .bus (bus)
    );

    typedef struct packed {
        logic        inc;
        logic        load;
        logic        sel;
        logic [7:0]  a;
        logic [3:0]  b;
        logic [11:0] ir;
        logic        ack;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic exp_t mk(input logic inc, input logic load, input logic sel,
                                input logic [7:0] a, input logic [3:0] b,
                                input logic [11:0] ir, input logic ack, input logic ill);
        exp_t e;
        e.inc = inc; e.load = load; e.sel = sel; e.a = a; e.b = b;
        e.ir = ir; e.ack = ack; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".cmd"},   {30'd0, bus.IncPC, bus.LoadPC}, 32'd0);
        chk({tag, ".sel"},   {31'd0, bus.SelPC}, 32'd0);
        chk({tag, ".a"},     {24'd0, bus.A}, 32'd0);
        chk({tag, ".b"},     {28'd0, bus.B}, 32'd0);
        chk({tag, ".ir"},    {20'd0, bus.IR}, 32'd0);
        chk({tag, ".flags"}, {29'd0, bus.IRQ_ack, bus.Halted, bus.Illegal}, 32'd0);
    endtask

    // Called at a negedge inside the first FETCH cycle; returns at the
    // negedge of the cycle following EXEC2.
    task automatic instr(input string name, input logic [11:0] im, input logic z,
                         input logic irq, input logic [7:0] pc, input int stall_n,
                         input exp_t e);
        exp_t got;
        $display("instr %s im=%03h z=%0d irq=%0d pc=%02h stall=%0d", name, im, z, irq, pc, stall_n);
        bus.IM_data = im;
        bus.Z       = z;
        bus.IRQ     = irq;
        bus.PC_in   = pc;
        bus.Stall   = (stall_n > 0);
        exp_q.push_back(e);
        chk({name, ".fetch_cmd"}, {30'd0, bus.IncPC, bus.LoadPC}, 32'd0);
        for (int i = 0; i < stall_n; i++) begin
            @(negedge CLK);
            if (i == stall_n - 1) bus.Stall = 1'b0;
            chk({name, ".stall_cmd"}, {30'd0, bus.IncPC, bus.LoadPC}, 32'd0);
        end
        @(negedge CLK);  // LATCH
        chk({name, ".latch_cmd"}, {30'd0, bus.IncPC, bus.LoadPC}, 32'd0);
        @(negedge CLK);  // EXEC1
        if (exp_q.size() == 0) begin
            chk({name, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = exp_q.pop_front();
            chk({name, ".e1_cmd"}, {30'd0, bus.IncPC, bus.LoadPC}, {30'd0, got.inc, got.load});
            chk({name, ".e1_sel"}, {31'd0, bus.SelPC}, {31'd0, got.sel});
            chk({name, ".e1_a"},   {24'd0, bus.A}, {24'd0, got.a});
            chk({name, ".e1_b"},   {28'd0, bus.B}, {28'd0, got.b});
            chk({name, ".e1_ir"},  {20'd0, bus.IR}, {20'd0, got.ir});
            chk({name, ".e1_ack"}, {31'd0, bus.IRQ_ack}, {31'd0, got.ack});
            chk({name, ".e1_ill"}, {31'd0, bus.Illegal}, {31'd0, got.ill});
            chk({name, ".e1_halted"}, {31'd0, bus.Halted}, 32'd0);
            @(negedge CLK);  // EXEC2
            chk({name, ".e2_cmd"}, {30'd0, bus.IncPC, bus.LoadPC}, {30'd0, got.inc, got.load});
            chk({name, ".e2_sel"}, {31'd0, bus.SelPC}, {31'd0, got.sel});
            chk({name, ".e2_ab"},  {20'd0, bus.A, bus.B}, {20'd0, got.a, got.b});
            chk({name, ".e2_pulses"}, {30'd0, bus.IRQ_ack, bus.Illegal}, 32'd0);
        end
        @(negedge CLK);
    endtask

    // Holds CLB for two cycles, then releases it and steps into FETCH.
    task automatic do_reset(input string name);
        CLB = 1'b1;
        repeat (2) @(negedge CLK);
        chk_all_zero(name);
        CLB = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        CLB         = 1'b1;
        bus.IM_data = 12'h000;
        bus.PC_in   = 8'h00;
        bus.Z       = 1'b0;
        bus.IRQ     = 1'b0;
        bus.Stall   = 1'b0;

        do_reset("reset");

        instr("nop0", 12'h000, 1'b0, 1'b0, 8'h00, 0, mk(1, 0, 0, 8'h00, 4'h0, 12'h000, 0, 0));
        instr("nop1", 12'h000, 1'b0, 1'b0, 8'h01, 0, mk(1, 0, 0, 8'h00, 4'h0, 12'h000, 0, 0));
        instr("nop2", 12'h000, 1'b0, 1'b0, 8'h02, 0, mk(1, 0, 0, 8'h00, 4'h0, 12'h000, 0, 0));
        instr("jmp",  12'h1A5, 1'b0, 1'b0, 8'h03, 0, mk(0, 1, 0, 8'hA5, 4'h0, 12'h1A5, 0, 0));
        instr("jz_z0", 12'h240, 1'b0, 1'b0, 8'hA5, 0, mk(1, 0, 0, 8'hA5, 4'h0, 12'h240, 0, 0));
        instr("jz_z1", 12'h240, 1'b1, 1'b0, 8'hA6, 0, mk(0, 1, 0, 8'h40, 4'h0, 12'h240, 0, 0));
        instr("irq",   12'h000, 1'b0, 1'b1, 8'h12, 0, mk(0, 1, 1, 8'h40, 4'hF, 12'h240, 1, 0));
        instr("irq_blocked", 12'h000, 1'b0, 1'b1, 8'h0F, 0, mk(1, 0, 1, 8'h40, 4'hF, 12'h000, 0, 0));
        instr("rti",   12'h600, 1'b0, 1'b1, 8'h10, 0, mk(0, 1, 0, 8'h12, 4'hF, 12'h600, 0, 0));
        instr("irq_retake", 12'h000, 1'b0, 1'b1, 8'h33, 0, mk(0, 1, 1, 8'h12, 4'hF, 12'h600, 1, 0));
        instr("rti2",  12'h600, 1'b0, 1'b0, 8'h0F, 0, mk(0, 1, 0, 8'h33, 4'hF, 12'h600, 0, 0));
        instr("rti_idle", 12'h600, 1'b0, 1'b0, 8'h33, 0, mk(1, 0, 0, 8'h33, 4'hF, 12'h600, 0, 0));
        instr("rst_op", 12'h50A, 1'b0, 1'b0, 8'h34, 0, mk(0, 1, 1, 8'h33, 4'hA, 12'h50A, 0, 0));
        instr("illegal_stall3", 12'h900, 1'b0, 1'b0, 8'h0A, 3, mk(1, 0, 1, 8'h33, 4'hA, 12'h900, 0, 1));
        instr("clr",   12'hF00, 1'b0, 1'b0, 8'h0B, 0, mk(1, 1, 1, 8'h33, 4'hA, 12'hF00, 0, 0));
        instr("irq_vs_halt", 12'h300, 1'b0, 1'b1, 8'h44, 0, mk(0, 1, 1, 8'h33, 4'hF, 12'hF00, 1, 0));
        instr("rti3",  12'h600, 1'b0, 1'b0, 8'h0F, 0, mk(0, 1, 0, 8'h44, 4'hF, 12'h600, 0, 0));
        instr("halt",  12'h300, 1'b0, 1'b0, 8'h44, 0, mk(0, 0, 0, 8'h44, 4'hF, 12'h300, 0, 0));

        // Parked in HALT: no commands regardless of IRQ.
        chk("halt.flag0", {31'd0, bus.Halted}, 32'd1);
        for (int i = 0; i < 50; i++) begin
            bus.IRQ = 1'($urandom_range(0, 1));
            @(negedge CLK);
            chk("halt.cmd", {29'd0, bus.IncPC, bus.LoadPC, bus.IRQ_ack}, 32'd0);
            chk("halt.flag", {31'd0, bus.Halted}, 32'd1);
        end
        bus.IRQ = 1'b0;

        do_reset("halt_reset");
        instr("post_halt_jmp", 12'h1C3, 1'b0, 1'b0, 8'h00, 0, mk(0, 1, 0, 8'hC3, 4'h0, 12'h1C3, 0, 0));

        // Reset asserted during EXEC1 drops the pending command at once.
        bus.IM_data = 12'h1C3;
        @(negedge CLK);  // LATCH
        @(negedge CLK);  // EXEC1
        chk("midreset.pre", {23'd0, bus.LoadPC, bus.A}, {23'd0, 1'b1, 8'hC3});
        CLB = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(negedge CLK);
        CLB = 1'b0;
        @(negedge CLK);
        instr("post_midreset_nop", 12'h000, 1'b0, 1'b0, 8'h00, 0, mk(1, 0, 0, 8'h00, 4'h0, 12'h000, 0, 0));

        chk("sb_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
